// File: rtl/axi4lite_mem_responder.sv
// AXI4-Lite memory responder: word-addressed 32-bit RAM with byte strobes,
// independent write and read engines, and a configurable response delay.
// Every output comes straight from a flop.
module axi4lite_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp
);
  localparam int         IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LAT    = 4'(LATENCY);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  // ---------------- write path ----------------
  w_state_t    w_state, w_state_nx;
  logic        aw_got, w_got;
  logic [31:0] w_addr_q, w_data_q;
  logic [3:0]  w_strb_q, w_cnt;
  logic        aw_fire, w_fire, aw_have, w_have, w_commit, w_in_range;
  logic [31:0] w_addr_cur, w_data_cur;
  logic [3:0]  w_strb_cur;
  logic [IDX_W-1:0] w_idx;

  assign aw_fire    = mem_axi_awvalid & mem_axi_awready;
  assign w_fire     = mem_axi_wvalid & mem_axi_wready;
  assign aw_have    = aw_got | aw_fire;
  assign w_have     = w_got | w_fire;
  // With LATENCY=0 the commit lands on the handshake edge itself, so the
  // incoming beat is used directly instead of the captured copy.
  assign w_addr_cur = aw_fire ? mem_axi_awaddr : w_addr_q;
  assign w_data_cur = w_fire ? mem_axi_wdata : w_data_q;
  assign w_strb_cur = w_fire ? mem_axi_wstrb : w_strb_q;
  assign w_in_range = {2'b00, w_addr_cur[31:2]} < 32'(MEM_WORDS);
  assign w_idx      = w_addr_cur[IDX_W+1:2];

  // Write FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_state_nx;
  end

  // Write FSM next state; w_commit marks the edge that raises bvalid.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nx = w_state;
    w_commit   = 1'b0;
    unique case (w_state)
      W_IDLE: if (aw_have && w_have) begin
        if (LAT == 4'd0) begin
          w_state_nx = W_RESP;
          w_commit   = 1'b1;
        end else begin
          w_state_nx = W_WAIT;
        end
      end
      W_WAIT: if (w_cnt == 4'd1) begin
        w_state_nx = W_RESP;
        w_commit   = 1'b1;
      end
      W_RESP: if (mem_axi_bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write channel registered outputs, capture registers and wait counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_got          <= 1'b0;
      w_got           <= 1'b0;
      w_addr_q        <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      w_cnt           <= '0;
      mem_axi_awready <= 1'b0;
      mem_axi_wready  <= 1'b0;
      mem_axi_bvalid  <= 1'b0;
      mem_axi_bresp   <= OKAY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (aw_fire) w_addr_q <= mem_axi_awaddr;
      if (w_fire) begin
        w_data_q <= mem_axi_wdata;
        w_strb_q <= mem_axi_wstrb;
      end
      aw_got          <= (w_state_nx == W_IDLE) && aw_have;
      w_got           <= (w_state_nx == W_IDLE) && w_have;
      mem_axi_awready <= (w_state_nx == W_IDLE) && !aw_have;
      mem_axi_wready  <= (w_state_nx == W_IDLE) && !w_have;
      if (w_state == W_IDLE && w_state_nx == W_WAIT) w_cnt <= LAT;
      else if (w_state == W_WAIT)                    w_cnt <= w_cnt - 4'd1;
      if (w_commit) begin
        mem_axi_bvalid <= 1'b1;
        mem_axi_bresp  <= w_in_range ? OKAY : SLVERR;
      end else if (w_state == W_RESP && mem_axi_bready) begin
        mem_axi_bvalid <= 1'b0;
      end
    end
  end

  // Byte-masked memory write on the commit edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; contents survive resetn and it maps onto block RAM.
    if (w_commit && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_cur[b]) mem[w_idx][8*b +: 8] <= w_data_cur[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t    r_state, r_state_nx;
  logic [31:0] r_addr_q, r_addr_cur;
  logic [3:0]  r_cnt;
  logic        ar_fire, r_load, r_in_range;
  logic [IDX_W-1:0] r_idx;

  assign ar_fire    = mem_axi_arvalid & mem_axi_arready;
  assign r_addr_cur = ar_fire ? mem_axi_araddr : r_addr_q;
  assign r_in_range = {2'b00, r_addr_cur[31:2]} < 32'(MEM_WORDS);
  assign r_idx      = r_addr_cur[IDX_W+1:2];

  // Read FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_state_nx;
  end

  // Read FSM next state; r_load marks the edge that raises rvalid.
  always_comb begin
    r_state_nx = r_state;
    r_load     = 1'b0;
    unique case (r_state)
      R_IDLE: if (ar_fire) begin
        if (LAT == 4'd0) begin
          r_state_nx = R_RESP;
          r_load     = 1'b1;
        end else begin
          r_state_nx = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt == 4'd1) begin
        r_state_nx = R_RESP;
        r_load     = 1'b1;
      end
      R_RESP: if (mem_axi_rready) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read channel registered outputs; the RAM is sampled pre-write on a shared edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr_q        <= '0;
      r_cnt           <= '0;
      mem_axi_arready <= 1'b0;
      mem_axi_rvalid  <= 1'b0;
      mem_axi_rresp   <= OKAY;
      mem_axi_rdata   <= '0;
    end else begin
      if (ar_fire) r_addr_q <= mem_axi_araddr;
      mem_axi_arready <= (r_state_nx == R_IDLE);
      if (r_state == R_IDLE && r_state_nx == R_WAIT) r_cnt <= LAT;
      else if (r_state == R_WAIT)                    r_cnt <= r_cnt - 4'd1;
      if (r_load) begin
        mem_axi_rvalid <= 1'b1;
        mem_axi_rresp  <= r_in_range ? OKAY : SLVERR;
        mem_axi_rdata  <= r_in_range ? mem[r_idx] : 32'h0;
      end else if (r_state == R_RESP && mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
      end
    end
  end

  // Protection bits and byte offsets carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot, w_addr_cur[1:0], r_addr_cur[1:0]};

endmodule
